// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the bus master arbiter.
package bus_arbiter_pkg;

  // Bus cycle width encoding used by the businterface.
  typedef enum logic [1:0] {
    CW_BYTE = 2'b00,
    CW_WORD = 2'b01,
    CW_LONG = 2'b10
  } t_cycle_width;

  // Arbiter FSM: waiting for a request, or owning the bus for one access.
  typedef enum logic {
    ARB_IDLE   = 1'b0,
    ARB_ACCESS = 1'b1
  } t_arb_state;

  localparam int ARB_MAX_CHANNELS = 8;

  // Width of a channel index; a single channel still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arbiter_picker.sv
// Combinational winner selection: fixed priority (lowest index) or
// round robin starting one past the last winner.
module rr_picker
  import bus_arbiter_pkg::*;
#(
  parameter int CHANNELS    = 2,
  parameter int ROUND_ROBIN = 0,
  localparam int IDX_W      = idx_width(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req_i,
  input  logic [IDX_W-1:0]    pointer_i,
  output logic [CHANNELS-1:0] winner_o,
  output logic [IDX_W-1:0]    index_o,
  output logic                valid_o
);

  generate
    if (CHANNELS == 1) begin : g_single
      assign winner_o = req_i;
      assign index_o  = '0;
      assign valid_o  = req_i[0];
    end else begin : g_multi
      logic [IDX_W-1:0] cand;

      // Scan from the least to the most preferred candidate so the last hit wins.
      always_comb begin
        index_o = '0;
        valid_o = 1'b0;
        cand    = '0;
        if (ROUND_ROBIN != 0) begin
          for (int k = CHANNELS; k >= 1; k--) begin
            cand = IDX_W'((int'(pointer_i) + k) % CHANNELS);
            if (req_i[cand]) begin
              index_o = cand;
              valid_o = 1'b1;
            end
          end
        end else begin
          for (int c = CHANNELS - 1; c >= 0; c--) begin
            cand = IDX_W'(c);
            if (req_i[cand]) begin
              index_o = cand;
              valid_o = 1'b1;
            end
          end
        end
      end

      for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_onehot
        assign winner_o[gi] = valid_o && (index_o == IDX_W'(gi));
      end
    end
  endgenerate

endmodule

// File: rtl/bus_arbiter.sv
// N-channel bus master arbiter: grants one requester, latches its cycle,
// drives it to the businterface and reports done / error per channel.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int CHANNELS       = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ROUND_ROBIN    = 0,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [CHANNELS-1:0]            ch_req,
  input  logic [CHANNELS-1:0]            ch_write,
  input  logic [CHANNELS*2-1:0]          ch_cycle_width,
  input  logic [CHANNELS*ADDR_WIDTH-1:0] ch_address,
  input  logic [CHANNELS*DATA_WIDTH-1:0] ch_data_out,
  output logic [CHANNELS-1:0]            ch_grant,
  output logic [CHANNELS-1:0]            ch_done,
  output logic [CHANNELS-1:0]            ch_error,
  output logic [DATA_WIDTH-1:0]          ch_data_in,
  output logic [ADDR_WIDTH-1:0]          bus_address,
  output logic [DATA_WIDTH-1:0]          bus_data_out,
  output logic [1:0]                     bus_cycle_width,
  output logic                           bus_read,
  output logic                           bus_write,
  input  logic [DATA_WIDTH-1:0]          bus_data_in,
  input  logic                           bus_ack,
  input  logic                           bus_error,
  output logic                           timeout
);

  localparam int IDX_W = idx_width(CHANNELS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W:0] TO_LIMIT = (CNT_W + 1)'(TIMEOUT_CYCLES);

  t_arb_state            state_q, state_d;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [CHANNELS-1:0]   grant_q, grant_d;
  logic [CHANNELS-1:0]   done_q, done_d;
  logic [CHANNELS-1:0]   error_q, error_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            width_q, width_d;
  logic                  dir_q, dir_d;
  logic [CNT_W-1:0]      wait_q, wait_d;
  logic                  timeout_q, timeout_d;

  logic [CNT_W:0]        wait_inc;
  logic [CHANNELS-1:0]   win_onehot;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_valid;

  logic [ADDR_WIDTH-1:0] ch_addr_arr  [CHANNELS];
  logic [DATA_WIDTH-1:0] ch_data_arr  [CHANNELS];
  logic [1:0]            ch_width_arr [CHANNELS];

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_unpack
      assign ch_addr_arr[gi]  = ch_address[ADDR_WIDTH*gi +: ADDR_WIDTH];
      assign ch_data_arr[gi]  = ch_data_out[DATA_WIDTH*gi +: DATA_WIDTH];
      assign ch_width_arr[gi] = ch_cycle_width[2*gi +: 2];
    end
  endgenerate

  rr_picker #(
    .CHANNELS    (CHANNELS),
    .ROUND_ROBIN (ROUND_ROBIN)
  ) u_picker (
    .req_i     (ch_req),
    .pointer_i (ptr_q),
    .winner_o  (win_onehot),
    .index_o   (win_idx),
    .valid_o   (win_valid)
  );

  assign wait_inc = {1'b0, wait_q} + 1'b1;

  // Next-state: arbitrate in IDLE, then finish the access on error, ack or timeout.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    done_d    = '0;
    error_d   = '0;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    width_d   = width_q;
    dir_d     = dir_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    case (state_q)
      ARB_IDLE: begin
        if (win_valid) begin
          state_d = ARB_ACCESS;
          grant_d = win_onehot;
          ptr_d   = win_idx;
          addr_d  = ch_addr_arr[win_idx];
          wdata_d = ch_data_arr[win_idx];
          width_d = ch_width_arr[win_idx];
          dir_d   = ch_write[win_idx];
          wait_d  = '0;
        end
      end
      ARB_ACCESS: begin
        // Error beats a simultaneous ack; an ack on the final wait cycle still counts.
        if (bus_error) begin
          error_d = grant_q;
          grant_d = '0;
          state_d = ARB_IDLE;
        end else if (bus_ack) begin
          done_d  = grant_q;
          grant_d = '0;
          state_d = ARB_IDLE;
          if (!dir_q) begin
            rdata_d = bus_data_in;
          end
        end else if ((TIMEOUT_CYCLES != 0) && (wait_inc == TO_LIMIT)) begin
          error_d   = grant_q;
          grant_d   = '0;
          timeout_d = 1'b1;
          state_d   = ARB_IDLE;
        end else begin
          wait_d = wait_inc[CNT_W-1:0];
        end
      end
      default: begin
        state_d = ARB_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // State and datapath registers; an active-low reset abandons any access in flight.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= ARB_IDLE;
      ptr_q     <= IDX_W'(CHANNELS - 1);
      grant_q   <= '0;
      done_q    <= '0;
      error_q   <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      width_q   <= CW_LONG;
      dir_q     <= 1'b0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      error_q   <= error_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      width_q   <= width_d;
      dir_q     <= dir_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
    end
  end

  assign ch_grant        = grant_q;
  assign ch_done         = done_q;
  assign ch_error        = error_q;
  assign ch_data_in      = rdata_q;
  assign bus_address     = addr_q;
  assign bus_data_out    = wdata_q;
  assign bus_cycle_width = width_q;
  assign bus_read        = (state_q == ARB_ACCESS) && !dir_q;
  assign bus_write       = (state_q == ARB_ACCESS) && dir_q;
  assign timeout         = timeout_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: instance A is 2-channel fixed priority, instance B
// is 3-channel round robin. A transaction-level model predicts every output
// each cycle; directed scenarios add hand-computed literal expectations.
module tb_bus_arbiter;
  import bus_arbiter_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic [2:0]  req  [2];
  logic [2:0]  wr   [2];
  logic [5:0]  cw   [2];
  logic [31:0] addr [2][3];
  logic [31:0] wdat [2][3];
  logic [31:0] bdi  [2];
  logic        ack  [2];
  logic        berr [2];

  logic [1:0]  gnt_a, done_a, err_a, cwo_a;
  logic [2:0]  gnt_b, done_b, err_b;
  logic [1:0]  cwo_b;
  logic [31:0] din_a, din_b, badr_a, badr_b, bdo_a, bdo_b;
  logic        rd_a, rd_b, wr_a, wr_b, to_a, to_b;

  bus_arbiter #(
    .CHANNELS(2), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(0), .TIMEOUT_CYCLES(15)
  ) dut_a (
    .clock(clk), .reset(rst_n),
    .ch_req(req[0][1:0]), .ch_write(wr[0][1:0]), .ch_cycle_width(cw[0][3:0]),
    .ch_address({addr[0][1], addr[0][0]}), .ch_data_out({wdat[0][1], wdat[0][0]}),
    .ch_grant(gnt_a), .ch_done(done_a), .ch_error(err_a), .ch_data_in(din_a),
    .bus_address(badr_a), .bus_data_out(bdo_a), .bus_cycle_width(cwo_a),
    .bus_read(rd_a), .bus_write(wr_a), .bus_data_in(bdi[0]),
    .bus_ack(ack[0]), .bus_error(berr[0]), .timeout(to_a)
  );

  bus_arbiter #(
    .CHANNELS(3), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ROUND_ROBIN(1), .TIMEOUT_CYCLES(15)
  ) dut_b (
    .clock(clk), .reset(rst_n),
    .ch_req(req[1]), .ch_write(wr[1]), .ch_cycle_width(cw[1]),
    .ch_address({addr[1][2], addr[1][1], addr[1][0]}),
    .ch_data_out({wdat[1][2], wdat[1][1], wdat[1][0]}),
    .ch_grant(gnt_b), .ch_done(done_b), .ch_error(err_b), .ch_data_in(din_b),
    .bus_address(badr_b), .bus_data_out(bdo_b), .bus_cycle_width(cwo_b),
    .bus_read(rd_b), .bus_write(wr_b), .bus_data_in(bdi[1]),
    .bus_ack(ack[1]), .bus_error(berr[1]), .timeout(to_b)
  );

  // Per-instance views of DUT outputs for the cycle compare.
  logic [2:0]  o_gnt [2], o_done [2], o_err [2];
  logic [1:0]  o_cw  [2];
  logic [31:0] o_din [2], o_adr [2], o_bdo [2];
  logic        o_rd  [2], o_wr  [2], o_to [2];
  assign o_gnt[0] = {1'b0, gnt_a};  assign o_gnt[1] = gnt_b;
  assign o_done[0] = {1'b0, done_a}; assign o_done[1] = done_b;
  assign o_err[0] = {1'b0, err_a};  assign o_err[1] = err_b;
  assign o_cw[0] = cwo_a;   assign o_cw[1] = cwo_b;
  assign o_din[0] = din_a;  assign o_din[1] = din_b;
  assign o_adr[0] = badr_a; assign o_adr[1] = badr_b;
  assign o_bdo[0] = bdo_a;  assign o_bdo[1] = bdo_b;
  assign o_rd[0] = rd_a;    assign o_rd[1] = rd_b;
  assign o_wr[0] = wr_a;    assign o_wr[1] = wr_b;
  assign o_to[0] = to_a;    assign o_to[1] = to_b;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  task automatic check(input int inst, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[inst %0d] got 0x%0h expected 0x%0h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Winner by the arbitration rules: lowest index, or first requester after ptr.
  function automatic int pick(input int n, input bit rr, input logic [2:0] r, input int ptr);
    if (rr) begin
      for (int k = 1; k <= n; k++) begin
        if (r[(ptr + k) % n]) return (ptr + k) % n;
      end
    end else begin
      for (int c = 0; c < n; c++) begin
        if (r[c]) return c;
      end
    end
    return -1;
  endfunction

  // Transaction-level model: is an access in progress, whom it belongs to, what it carries.
  bit          m_busy [2];
  int          m_owner [2], m_ptr [2], m_wait [2];
  bit          m_wr [2], m_to [2];
  logic [31:0] m_addr [2], m_wdat [2], m_din [2];
  logic [1:0]  m_cw [2];
  logic [2:0]  m_done [2], m_err [2];

  always @(posedge clk) begin : model
    int n, w;
    for (int i = 0; i < 2; i++) begin
      n = (i == 0) ? 2 : 3;
      m_done[i] = '0;
      m_err[i]  = '0;
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_owner[i] = 0; m_ptr[i] = n - 1; m_wait[i] = 0;
        m_wr[i] = 1'b0; m_to[i] = 1'b0; m_addr[i] = '0; m_wdat[i] = '0;
        m_din[i] = '0; m_cw[i] = CW_LONG;
      end else if (m_busy[i]) begin
        if (berr[i]) begin
          m_err[i][m_owner[i]] = 1'b1;
          m_busy[i] = 1'b0;
        end else if (ack[i]) begin
          m_done[i][m_owner[i]] = 1'b1;
          if (!m_wr[i]) m_din[i] = bdi[i];
          m_busy[i] = 1'b0;
        end else begin
          m_wait[i]++;
          if (m_wait[i] == 15) begin
            m_err[i][m_owner[i]] = 1'b1;
            m_to[i] = 1'b1;
            m_busy[i] = 1'b0;
          end
        end
      end else begin
        w = pick(n, (i == 1), req[i], m_ptr[i]);
        if (w >= 0) begin
          m_busy[i] = 1'b1; m_owner[i] = w; m_wait[i] = 0; m_ptr[i] = w;
          m_wr[i] = wr[i][w]; m_addr[i] = addr[i][w]; m_wdat[i] = wdat[i][w];
          m_cw[i] = cw[i][2*w +: 2];
        end
      end
    end
  end

  // Every cycle, every output of both instances against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check(i, "grant",   o_gnt[i],  m_busy[i] ? (32'd1 << m_owner[i]) : 32'd0);
        check(i, "done",    o_done[i], m_done[i]);
        check(i, "error",   o_err[i],  m_err[i]);
        check(i, "rd",      o_rd[i],   m_busy[i] && !m_wr[i]);
        check(i, "wr",      o_wr[i],   m_busy[i] && m_wr[i]);
        check(i, "addr",    o_adr[i],  m_addr[i]);
        check(i, "wdata",   o_bdo[i],  m_wdat[i]);
        check(i, "cw",      o_cw[i],   m_cw[i]);
        check(i, "data_in", o_din[i],  m_din[i]);
        check(i, "timeout", o_to[i],   m_to[i]);
      end
    end
  end

  int rd_cnt;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req[i] = '0; wr[i] = '0; cw[i] = 6'b10_10_10;
      bdi[i] = '0; ack[i] = 1'b0; berr[i] = 1'b0;
      for (int c = 0; c < 3; c++) begin
        addr[i][c] = '0; wdat[i][c] = '0;
      end
    end
    tick();
    chk_en = 1'b1;
    tick();
    check(0, "rst_grant", gnt_a, 0);
    check(0, "rst_cw", cwo_a, CW_LONG);
    check(1, "rst_cw", cwo_b, CW_LONG);
    rst_n = 1'b1;

    // Reset during a pending read abandons it; channel 0 wins afterwards.
    req[0] = 3'b010; addr[0][1] = 32'h0000_0400;
    tick();
    check(0, "t1_grant", gnt_a, 2'b10);
    check(0, "t1_read", rd_a, 1);
    rst_n = 1'b0;
    tick();
    check(0, "t1_rst_grant", gnt_a, 0);
    check(0, "t1_rst_read", rd_a, 0);
    check(0, "t1_rst_done", done_a, 0);
    rst_n = 1'b1; req[0] = 3'b011;
    tick();
    check(0, "t1_first", gnt_a, 2'b01);

    // Fixed priority with both requesting: channel 1 starves.
    ack[0] = 1'b1;
    tick();
    check(0, "t2_done", done_a, 2'b01);
    repeat (3) begin
      tick();
      check(0, "t2_grant", gnt_a, 2'b01);
      tick();
      check(0, "t2_done", done_a, 2'b01);
    end
    req[0] = '0; ack[0] = 1'b0;
    tick();

    // Byte read on channel 1 acked after three wait cycles; request dropped meanwhile.
    req[0] = 3'b010; wr[0] = '0; addr[0][1] = 32'h0000_1000; cw[0][3:2] = CW_BYTE;
    tick();
    req[0] = '0; rd_cnt = 0;
    check(0, "t4_addr", badr_a, 32'h0000_1000);
    check(0, "t4_cw", cwo_a, CW_BYTE);
    for (int k = 1; k <= 4; k++) begin
      if (rd_a) rd_cnt++;
      if (k == 4) begin
        ack[0] = 1'b1; bdi[0] = 32'hDEAD_BEEF;
      end
      tick();
    end
    check(0, "t4_rd_cycles", rd_cnt, 4);
    check(0, "t4_done", done_a, 2'b10);
    check(0, "t4_rd_drop", rd_a, 0);
    check(0, "t4_data", din_a, 32'hDEAD_BEEF);
    ack[0] = 1'b0; bdi[0] = '0;
    tick();
    check(0, "t4_hold", din_a, 32'hDEAD_BEEF);
    check(0, "t4_pulse", done_a, 0);

    // Write with ack and error together; address change ignored mid-access.
    req[0] = 3'b001; wr[0] = 3'b001; addr[0][0] = 32'h0000_2000; wdat[0][0] = 32'h1234_5678;
    tick();
    req[0] = '0;
    check(0, "t6_write", wr_a, 1);
    check(0, "t6_wdata", bdo_a, 32'h1234_5678);
    addr[0][0] = 32'hFFFF_0000;
    tick();
    check(0, "t6_addr_latched", badr_a, 32'h0000_2000);
    ack[0] = 1'b1; berr[0] = 1'b1; bdi[0] = 32'h0BAD_0BAD;
    tick();
    check(0, "t6_error", err_a, 2'b01);
    check(0, "t6_no_done", done_a, 0);
    check(0, "t6_data_kept", din_a, 32'hDEAD_BEEF);
    ack[0] = 1'b0; berr[0] = 1'b0; wr[0] = '0; bdi[0] = '0;
    tick();

    // No ack: error in the 16th cycle after the strobe rises, timeout sticks.
    req[0] = 3'b010;
    tick();
    req[0] = '0;
    for (int c = 1; c <= 15; c++) begin
      check(0, "t5_wait_read", rd_a, 1);
      tick();
    end
    check(0, "t5_error", err_a, 2'b10);
    check(0, "t5_rd_drop", rd_a, 0);
    check(0, "t5_timeout", to_a, 1);
    tick();
    check(0, "t5_sticky", to_a, 1);
    check(0, "t5_pulse", err_a, 0);

    // Round robin over three channels: 0,1,2,0.
    req[1] = 3'b111; ack[1] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check(1, "t3_grant", gnt_b, 32'd1 << (k % 3));
      tick();
      check(1, "t3_done", done_b, 32'd1 << (k % 3));
    end
    req[1] = '0; ack[1] = 1'b0;
    tick();

    // Ack arriving on the last wait cycle completes normally.
    req[1] = 3'b100;
    tick();
    req[1] = '0;
    repeat (14) tick();
    ack[1] = 1'b1; bdi[1] = 32'hCAFE_F00D;
    tick();
    check(1, "ack15_done", done_b, 3'b100);
    check(1, "ack15_no_err", err_b, 0);
    check(1, "ack15_no_timeout", to_b, 0);
    check(1, "ack15_data", din_b, 32'hCAFE_F00D);
    ack[1] = 1'b0; bdi[1] = '0;
    tick();

    // Only reset clears the sticky timeout.
    rst_n = 1'b0;
    tick();
    check(0, "rst_clears_timeout", to_a, 0);
    rst_n = 1'b1;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
